// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared memory-op encodings, size codes and M-stage FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [5:0] c_OP_LB  = 6'h01;
    localparam logic [5:0] c_OP_LBU = 6'h02;
    localparam logic [5:0] c_OP_LH  = 6'h03;
    localparam logic [5:0] c_OP_LHU = 6'h04;
    localparam logic [5:0] c_OP_LW  = 6'h05;
    localparam logic [5:0] c_OP_SB  = 6'h06;
    localparam logic [5:0] c_OP_SH  = 6'h07;
    localparam logic [5:0] c_OP_SW  = 6'h08;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ADDR = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DONE      = 3'd3,
        ST_DRAIN     = 3'd4
    } mau_state_t;

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            c_OP_LB, c_OP_LBU, c_OP_SB: op_size = c_SIZE_BYTE;
            c_OP_LH, c_OP_LHU, c_OP_SH: op_size = c_SIZE_HALF;
            default:                    op_size = c_SIZE_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Load lane select and sign/zero extension (shared with forwarding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_op)
            c_OP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: o_result = {24'd0, w_byte};
            c_OP_LH:  o_result = {{16{w_half[15]}}, w_half};
            c_OP_LHU: o_result = {16'd0, w_half};
            default:  o_result = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : M-stage load/store unit driving an sram-like data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        M_mem_en,
    input  logic        M_mem_ren,
    input  logic        M_mem_wen,
    input  logic [5:0]  M_mem_op,
    input  logic [31:0] M_mem_addr,
    input  logic [31:0] M_mem_va,
    input  logic [31:0] M_mem_wdata,
    input  logic        M_ena,
    input  logic        M_flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] M_mem_rdata,
    output logic        M_mem_stall,
    output logic        M_adel,
    output logic        M_ades,
    output logic [31:0] M_badvaddr
);

    mau_state_t  r_state;
    mau_state_t  w_next;
    logic        r_flush;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [5:0]  r_op;
    logic [1:0]  r_size;
    logic        r_wr;
    logic        r_load;

    logic        w_ld_op;
    logic        w_st_op;
    logic        w_load;
    logic        w_store;
    logic [1:0]  w_size;
    logic        w_misalign;
    logic        w_go;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;

    always_comb begin
        w_ld_op = (M_mem_op == c_OP_LB) || (M_mem_op == c_OP_LBU) || (M_mem_op == c_OP_LH) ||
                  (M_mem_op == c_OP_LHU) || (M_mem_op == c_OP_LW);
        w_st_op = (M_mem_op == c_OP_SB) || (M_mem_op == c_OP_SH) || (M_mem_op == c_OP_SW);
        w_load  = M_mem_en && M_mem_ren && w_ld_op;
        w_store = M_mem_en && M_mem_wen && w_st_op;
        w_size  = op_size(M_mem_op);
        w_misalign = ((w_size == c_SIZE_HALF) && M_mem_addr[0]) ||
                     ((w_size == c_SIZE_WORD) && (M_mem_addr[1:0] != 2'd0));
        w_go    = (w_load || w_store) && !w_misalign && !M_flush;
        case (w_size)
            c_SIZE_BYTE: w_wdata = {4{M_mem_wdata[7:0]}};
            c_SIZE_HALF: w_wdata = {2{M_mem_wdata[15:0]}};
            default:     w_wdata = M_mem_wdata;
        endcase
        M_adel     = w_load && w_misalign;
        M_ades     = w_store && w_misalign;
        M_badvaddr = (M_adel || M_ades) ? M_mem_va : 32'd0;
    end

    load_align u_load_align (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_rdata   (data_rdata),
        .o_result  (w_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A response that arrives together with a flush is dropped on the spot;
    // waiting in DRAIN for it would never end.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_next = data_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                if (data_addr_ok) begin
                    w_next = (r_flush || M_flush) ? ST_DRAIN : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (M_flush) begin
                    w_next = data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (data_data_ok) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (M_ena || M_flush) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (data_data_ok) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields are captured at issue so an accepted-pending request stays
    // intact even if the pipeline flushes M underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush <= 1'b0;
            r_rdata <= 32'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_op    <= 6'd0;
            r_size  <= 2'd0;
            r_wr    <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_go) begin
                r_addr  <= M_mem_addr;
                r_wdata <= w_wdata;
                r_op    <= M_mem_op;
                r_size  <= w_size;
                r_wr    <= M_mem_wen;
                r_load  <= w_load;
            end
            if (w_next == ST_IDLE) begin
                r_flush <= 1'b0;
            end else if ((r_state == ST_WAIT_ADDR) && M_flush) begin
                r_flush <= 1'b1;
            end
            if ((r_state == ST_WAIT_DATA) && data_data_ok && !M_flush) begin
                r_rdata <= r_load ? w_aligned : 32'd0;
            end
        end
    end

    always_comb begin
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'd0;
        data_wdata  = 32'd0;
        M_mem_stall = 1'b0;
        M_mem_rdata = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    data_req    = 1'b1;
                    data_wr     = M_mem_wen;
                    data_size   = w_size;
                    data_addr   = M_mem_addr;
                    data_wdata  = w_wdata;
                    M_mem_stall = 1'b1;
                end
            end
            ST_WAIT_ADDR: begin
                data_req    = 1'b1;
                data_wr     = r_wr;
                data_size   = r_size;
                data_addr   = r_addr;
                data_wdata  = r_wdata;
                M_mem_stall = 1'b1;
            end
            ST_WAIT_DATA: M_mem_stall = 1'b1;
            ST_DONE:      M_mem_rdata = r_rdata;
            ST_DRAIN:     M_mem_stall = M_mem_en;
            default:      M_mem_stall = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        M_mem_en;
    logic        M_mem_ren;
    logic        M_mem_wen;
    logic [5:0]  M_mem_op;
    logic [31:0] M_mem_addr;
    logic [31:0] M_mem_va;
    logic [31:0] M_mem_wdata;
    logic        M_ena;
    logic        M_flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] M_mem_rdata;
    logic        M_mem_stall;
    logic        M_adel;
    logic        M_ades;
    logic [31:0] M_badvaddr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .M_mem_en     (M_mem_en),
        .M_mem_ren    (M_mem_ren),
        .M_mem_wen    (M_mem_wen),
        .M_mem_op     (M_mem_op),
        .M_mem_addr   (M_mem_addr),
        .M_mem_va     (M_mem_va),
        .M_mem_wdata  (M_mem_wdata),
        .M_ena        (M_ena),
        .M_flush      (M_flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .M_mem_rdata  (M_mem_rdata),
        .M_mem_stall  (M_mem_stall),
        .M_adel       (M_adel),
        .M_ades       (M_ades),
        .M_badvaddr   (M_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic ren, input logic wen, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        M_mem_en    = 1'b1;
        M_mem_ren   = ren;
        M_mem_wen   = wen;
        M_mem_op    = op;
        M_mem_addr  = addr;
        M_mem_va    = addr;
        M_mem_wdata = wdata;
    endtask

    task automatic clr_acc();
        M_mem_en    = 1'b0;
        M_mem_ren   = 1'b0;
        M_mem_wen   = 1'b0;
        M_mem_op    = 6'd0;
        M_mem_addr  = 32'd0;
        M_mem_va    = 32'd0;
        M_mem_wdata = 32'd0;
    endtask

    // Issue a load with addr_ok at once, data_ok next cycle, check in DONE.
    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        step();
        set_acc(1'b1, 1'b0, op, addr, 32'd0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        M_ena        = 1'b1;
        #1;
        chk(tag, M_mem_rdata, exp);
        step();
        M_ena = 1'b0;
        clr_acc();
    endtask

    initial begin
        rst          = 1'b1;
        M_ena        = 1'b0;
        M_flush      = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        clr_acc();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_ctrl", {26'd0, data_req, data_wr, data_size, M_mem_stall, M_adel}, 32'd0);
        chk("reset_ades", {31'd0, M_ades}, 32'd0);
        chk("reset_addr", data_addr, 32'd0);
        chk("reset_wdata", data_wdata, 32'd0);
        chk("reset_rdata", M_mem_rdata, 32'd0);
        chk("reset_badv", M_badvaddr, 32'd0);

        // LW with addr_ok immediately, data_ok two cycles later
        step();
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h0000_1004, 32'd0);
        data_addr_ok = 1'b1;
        #1;
        chk("lw_req", {31'd0, data_req}, 32'd1);
        chk("lw_size", {30'd0, data_size}, 32'd2);
        chk("lw_addr", data_addr, 32'h0000_1004);
        chk("lw_wr", {31'd0, data_wr}, 32'd0);
        chk("lw_stall0", {31'd0, M_mem_stall}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("lw_stall1", {31'd0, M_mem_stall}, 32'd1);
        chk("lw_req_wd", {31'd0, data_req}, 32'd0);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        #1;
        chk("lw_stall2", {31'd0, M_mem_stall}, 32'd1);
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        M_ena        = 1'b1;
        #1;
        chk("lw_done_stall", {31'd0, M_mem_stall}, 32'd0);
        chk("lw_done_rdata", M_mem_rdata, 32'h1234_5678);
        step();
        M_ena = 1'b0;
        clr_acc();
        #1;
        chk("lw_idle_rdata", M_mem_rdata, 32'd0);

        do_load("lb_lane3", c_OP_LB, 32'h0000_2003, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lbu_lane3", c_OP_LBU, 32'h0000_2003, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("lb_lane1", c_OP_LB, 32'h0000_2001, 32'h0000_7F00, 32'h0000_007F);
        do_load("lh_upper", c_OP_LH, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu_lower", c_OP_LHU, 32'h0000_2000, 32'h1234_F00D, 32'h0000_F00D);

        // SH replicates the halfword; store DONE reports zero
        step();
        set_acc(1'b0, 1'b1, c_OP_SH, 32'h0000_3002, 32'h0000_BEEF);
        data_addr_ok = 1'b1;
        #1;
        chk("sh_size", {30'd0, data_size}, 32'd1);
        chk("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        chk("sh_wr", {31'd0, data_wr}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        step();
        data_data_ok = 1'b0;
        M_ena        = 1'b1;
        #1;
        chk("sh_done_rdata", M_mem_rdata, 32'd0);
        chk("sh_done_stall", {31'd0, M_mem_stall}, 32'd0);
        step();
        M_ena = 1'b0;
        clr_acc();

        // Misaligned accesses raise exceptions and never issue
        step();
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h8000_0002, 32'd0);
        data_addr_ok = 1'b1;
        #1;
        chk("adel_flag", {31'd0, M_adel}, 32'd1);
        chk("adel_ades", {31'd0, M_ades}, 32'd0);
        chk("adel_badv", M_badvaddr, 32'h8000_0002);
        chk("adel_req", {31'd0, data_req}, 32'd0);
        chk("adel_stall", {31'd0, M_mem_stall}, 32'd0);
        step();
        #1;
        chk("adel_req2", {31'd0, data_req}, 32'd0);
        set_acc(1'b0, 1'b1, c_OP_SH, 32'h0000_5001, 32'd0);
        #1;
        chk("ades_flag", {31'd0, M_ades}, 32'd1);
        chk("ades_badv", M_badvaddr, 32'h0000_5001);
        chk("ades_req", {31'd0, data_req}, 32'd0);
        step();
        data_addr_ok = 1'b0;
        clr_acc();

        // addr_ok held low: request and fields stay put
        step();
        set_acc(1'b0, 1'b1, c_OP_SB, 32'h0000_4001, 32'h1234_56A5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wa_req", {31'd0, data_req}, 32'd1);
            chk("wa_addr", data_addr, 32'h0000_4001);
            chk("wa_size", {30'd0, data_size}, 32'd0);
            chk("wa_wdata", data_wdata, 32'hA5A5_A5A5);
            step();
        end
        data_addr_ok = 1'b1;
        #1;
        chk("wa_req_last", {31'd0, data_req}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        M_ena        = 1'b1;
        #1;
        chk("sb_done_rdata", M_mem_rdata, 32'd0);
        step();
        M_ena = 1'b0;
        clr_acc();

        // Flush in WAIT_DATA: drain stale response, hold off the new LW
        step();
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h0000_6000, 32'd0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        M_flush      = 1'b1;
        step();
        M_flush = 1'b0;
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h0000_7000, 32'd0);
        data_addr_ok = 1'b1;
        #1;
        chk("drain_req0", {31'd0, data_req}, 32'd0);
        chk("drain_stall", {31'd0, M_mem_stall}, 32'd1);
        step();
        #1;
        chk("drain_req1", {31'd0, data_req}, 32'd0);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("drain_req2", {31'd0, data_req}, 32'd0);
        chk("drain_rdata", M_mem_rdata, 32'd0);
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        #1;
        chk("post_drain_req", {31'd0, data_req}, 32'd1);
        chk("post_drain_addr", data_addr, 32'h0000_7000);
        chk("post_drain_rdata", M_mem_rdata, 32'd0);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        M_ena        = 1'b1;
        #1;
        chk("post_drain_done", M_mem_rdata, 32'hCAFE_F00D);
        step();
        M_ena = 1'b0;
        clr_acc();

        // Flush while waiting for addr_ok: request is not retracted, then drained
        step();
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h0000_8000, 32'd0);
        step();
        clr_acc();
        M_flush = 1'b1;
        #1;
        chk("wa_flush_req", {31'd0, data_req}, 32'd1);
        chk("wa_flush_addr", data_addr, 32'h0000_8000);
        step();
        M_flush      = 1'b0;
        data_addr_ok = 1'b1;
        #1;
        chk("wa_flush_req2", {31'd0, data_req}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("wa_drain_req", {31'd0, data_req}, 32'd0);
        chk("wa_drain_stall", {31'd0, M_mem_stall}, 32'd0);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        #1;
        chk("wa_drain_rdata", M_mem_rdata, 32'd0);

        // Reset in WAIT_DATA, stale data_ok afterwards is ignored
        step();
        set_acc(1'b1, 1'b0, c_OP_LW, 32'h0000_9000, 32'd0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        clr_acc();
        rst = 1'b1;
        step();
        rst          = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        #1;
        chk("rst_ctrl", {27'd0, data_req, data_wr, data_size, M_mem_stall}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_rdata", M_mem_rdata, 32'd0);
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        #1;
        chk("rst_stale_rdata", M_mem_rdata, 32'd0);
        chk("rst_stale_stall", {31'd0, M_mem_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset sampled on posedge clk.
REQ-003 SHALL have M_mem_en / M_mem_ren / M_mem_wen, input, 1 each, access valid / load / store from the EX/MEM register.
REQ-004 SHALL have M_mem_op, input, 6, access-type code from the shared package; M_mem_addr, input, 32, physical address; M_mem_va, input, 32, virtual address; M_mem_wdata, input, 32, store data.
REQ-005 SHALL have M_ena, input, 1, pipeline advances out of M this cycle; M_flush, input, 1, exception/eret flush of M.
REQ-006 SHALL have data_req, data_wr (output, 1), data_size (output, 2), data_addr and data_wdata (output, 32), and data_addr_ok, data_data_ok (input, 1), data_rdata (input, 32): the sram-like data port.
REQ-007 SHALL have M_mem_rdata, output, 32, aligned and extended load result; M_mem_stall, output, 1; M_adel, M_ades, output, 1; M_badvaddr, output, 32.

Function
REQ-008 SHALL decode M_mem_op into LB, LBU, LH, LHU, LW, SB, SH, SW; any other op with M_mem_en=1 SHALL be treated as no access.
REQ-009 SHALL raise M_adel (load) or M_ades (store) combinationally when M_mem_en=1 and the access is misaligned: half with addr[0]=1, or word with addr[1:0]!=0. M_badvaddr SHALL equal M_mem_va; otherwise M_badvaddr SHALL be 0.
REQ-010 SHALL issue a request only for a valid, aligned, unflushed access ("go").
REQ-011 data_size SHALL be 0 for byte, 1 for half, 2 for word; data_addr SHALL equal M_mem_addr; data_wr SHALL equal M_mem_wen.
REQ-012 data_wdata SHALL replicate the byte into all 4 lanes for SB, the halfword into both halves for SH, and pass through for SW.
REQ-013 SHALL implement the FSM IDLE, WAIT_ADDR, WAIT_DATA, DONE, DRAIN.
REQ-014 In IDLE, data_req SHALL be 1 on go. With data_addr_ok=1 the next state SHALL be WAIT_DATA, else WAIT_ADDR.
REQ-015 In WAIT_ADDR, data_req SHALL stay 1 with stable fields. On data_addr_ok the next state SHALL be WAIT_DATA, or DRAIN if a flush was latched.
REQ-016 In WAIT_DATA, data_req SHALL be 0. On data_data_ok the aligned result SHALL be registered and the next state SHALL be DONE; with M_flush the next state SHALL be DRAIN.
REQ-017 In DONE, M_mem_rdata SHALL come from the register. On M_ena the next state SHALL be IDLE, and on M_flush as well.
REQ-018 In DRAIN, data_req SHALL be 0 and rdata SHALL be discarded. On data_data_ok the next state SHALL be IDLE.
REQ-019 M_mem_stall SHALL be 1 in IDLE on go, in WAIT_ADDR, in WAIT_DATA, and in DRAIN while M_mem_en=1; it SHALL be 0 otherwise, including DONE.
REQ-020 M_flush in WAIT_ADDR SHALL set a sticky flag that is cleared on entering IDLE; an issued request SHALL never be retracted.
REQ-021 The load result SHALL select the lane by addr[1:0] (byte) or addr[1] (half), sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-022 For stores, DONE SHALL still be entered on data_data_ok, with M_mem_rdata=0.

Reset
REQ-023 rst SHALL force state IDLE, the flush flag to 0, and the result register to 0; rst SHALL override any in-flight transaction, and the outstanding response after reset SHALL be ignored.
REQ-024 In the cycle after reset with no access, all outputs SHALL be 0.

Structure
REQ-025 The mem_op encodings, size codes and the FSM state enum SHALL live in the shared cpu package.
REQ-026 Load lane selection and extension SHALL be one combinational sub-module, load_align, reused by the forwarding path.

Verification
REQ-027 LW at 0x00001004, addr_ok same cycle, data_ok 2 cycles later with 0x12345678 -> stall high 3 cycles, then M_mem_rdata=0x12345678 in DONE.
REQ-028 LB at addr[1:0]=3 with rdata 0x80FFFFFF -> 0xFFFFFF80; LBU with the same inputs -> 0x00000080.
REQ-029 SH at addr[1:0]=2 with wdata 0x0000BEEF -> data_size=1, data_wdata=0xBEEFBEEF, data_wr=1.
REQ-030 LW at va 0x80000002 -> M_adel=1, M_badvaddr=0x80000002, data_req never asserted, stall 0.
REQ-031 M_flush in WAIT_DATA, data_ok 3 cycles later, then a new LW -> DRAIN, the new request is held off until the stale data_ok, and the stale data is not delivered.
REQ-032 addr_ok held low 4 cycles in WAIT_ADDR -> data_req held 1 with constant addr/size/wdata; rst mid-WAIT_DATA -> IDLE with all outputs 0.
